// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller.
// Holds the scan FSM encoding, the digit count and the hex glyph table.
package seg_pkg;

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS = 4;

  // Segment patterns, bit6..bit0 = g..a, active-high
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_glyph.sv
// Combinational hex nibble to seven-segment pattern decoder.
module hex_glyph
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = GLYPHS[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller with a one-deep pending buffer.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  if (SCAN_DIV < DEAD_CYCLES + 2) begin : g_bad_cfg
    $error("seg_scan_ctrl: SCAN_DIV must be at least DEAD_CYCLES+2");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       idx;
  scan_state_t      state;
  scan_state_t      state_next;
  logic [15:0]      display;
  logic [15:0]      pending;
  logic             pending_full;
  logic             cnt_wrap;
  logic             boundary;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             blank;
  logic [6:0]       seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  assign cnt_wrap   = (cnt == CNT_W'(SCAN_DIV - 1));
  assign boundary   = cnt_wrap && (idx == 2'd3);
  assign cnt_next   = cnt_wrap ? '0 : cnt + 1'b1;
  assign nibble     = display[{idx, 2'b00} +: 4];
  assign data_ready = !pending_full;

  hex_glyph u_hex_glyph (
    .nibble  (nibble),
    .pattern (glyph)
  );

  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx)
      2'd3:    blank = (display[15:12] == 4'h0);
      2'd2:    blank = (display[15:8] == 8'h00);
      2'd1:    blank = (display[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= cnt_next;
      if (cnt_wrap)
        idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= DEAD;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    seg_d      = '0;
    an_d       = '1;
    case (state)
      DEAD: begin
        if (cnt_next >= CNT_W'(DEAD_CYCLES))
          state_next = DRIVE;
      end
      DRIVE: begin
        if (cnt_wrap && (DEAD_CYCLES > 0))
          state_next = DEAD;
        an_d  = ~(NUM_DIGITS'(1) << idx);
        seg_d = blank ? 7'h00 : glyph;
      end
      default: state_next = DEAD;
    endcase
  end

  // Registered pins give exactly one cycle of latency from the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= '0;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= boundary;
    end
  end

  // Display only changes at the frame boundary; an accept there lands in pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display      <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (boundary && pending_full) begin
      display      <= pending;
      pending_full <= 1'b0;
    end else if (data_valid && !pending_full) begin
      pending      <= data_in;
      pending_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with SCAN_DIV=8, DEAD_CYCLES=2.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  logic [6:0] glyph_tb [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg_scan_ctrl #(.SCAN_DIV(8), .DEAD_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic v);
    data_in    = d;
    data_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Pins after edge k reflect scan state s=k-1 with the given display contents
  task automatic checkSlot(input logic [15:0] disp);
    int s, c, i;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       blank;
    s = edges - 1;
    c = s % 8;
    i = (s / 8) % 4;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (i == 3 && disp[15:12] == 4'h0) || (i == 2 && disp[15:8] == 8'h00) ||
            (i == 1 && disp[15:4] == 12'h000);
`endif
    if (c < 2) begin
      exp_an  = 4'b1111;
      exp_seg = 7'h00;
    end else begin
      exp_an  = ~(4'b0001 << i);
      exp_seg = blank ? 7'h00 : glyph_tb[disp[i*4 +: 4]];
    end
    checkOutput($sformatf("an@%0d", edges), {12'b0, an}, {12'b0, exp_an});
    checkOutput($sformatf("seg@%0d", edges), {9'b0, seg}, {9'b0, exp_seg});
    checkOutput($sformatf("frame_done@%0d", edges), {15'b0, frame_done}, {15'b0, (s % 32) == 31});
  endtask

  task automatic runTo(input int target, input logic [15:0] disp);
    while (edges < target) begin
      step();
      checkSlot(disp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_an", {12'b0, an}, 16'h000F);
    checkOutput("rst_seg", {9'b0, seg}, 16'h0000);
    checkOutput("rst_ready", {15'b0, data_ready}, 16'h0001);
    checkOutput("rst_frame_done", {15'b0, frame_done}, 16'h0000);

    rst_n = 1'b1;
    edges = 0;
    step();
    step();
    checkOutput("dead_an", {12'b0, an}, 16'h000F);
    step();
    checkOutput("first_drive_an", {12'b0, an}, 16'h000E);
    checkOutput("first_drive_seg", {9'b0, seg}, 16'h003F);

    // Scan of 1234
    applyStimulus(16'h1234, 1'b1);
    step();
    applyStimulus(16'h0000, 1'b0);
    checkSlot(16'h0000);
    checkOutput("load_ready_low", {15'b0, data_ready}, 16'h0000);
    runTo(32, 16'h0000);
    runTo(64, 16'h1234);

    // Backpressure: ABCD pending, 5555 waits for the boundary
    applyStimulus(16'hABCD, 1'b1);
    step();
    checkSlot(16'h1234);
    checkOutput("bp_ready_after_accept", {15'b0, data_ready}, 16'h0000);
    applyStimulus(16'h5555, 1'b1);
    while (edges < 96) begin
      step();
      checkSlot(16'h1234);
      if (edges < 96)
        checkOutput($sformatf("bp_ready_low@%0d", edges), {15'b0, data_ready}, 16'h0000);
    end
    checkOutput("bp_ready_at_boundary", {15'b0, data_ready}, 16'h0001);
    step();
    applyStimulus(16'h0000, 1'b0);
    checkSlot(16'hABCD);
    checkOutput("bp_second_accept", {15'b0, data_ready}, 16'h0000);
    runTo(128, 16'hABCD);

    // Accept in the boundary cycle is not bypassed to the next frame
    runTo(159, 16'h5555);
    checkOutput("coll_ready", {15'b0, data_ready}, 16'h0001);
    applyStimulus(16'hF00F, 1'b1);
    step();
    applyStimulus(16'h0000, 1'b0);
    checkSlot(16'h5555);
    checkOutput("coll_ready_low", {15'b0, data_ready}, 16'h0000);
    runTo(192, 16'h5555);
    runTo(224, 16'hF00F);

    // Leading zeros
    applyStimulus(16'h0070, 1'b1);
    step();
    applyStimulus(16'h0000, 1'b0);
    checkSlot(16'hF00F);
    runTo(256, 16'hF00F);
    runTo(288, 16'h0070);

    // Mid-frame reset while driving digit 2
    runTo(307, 16'h0070);
    checkOutput("pre_reset_an", {12'b0, an}, 16'h000B);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_an", {12'b0, an}, 16'h000F);
    checkOutput("async_rst_seg", {9'b0, seg}, 16'h0000);
    checkOutput("async_rst_ready", {15'b0, data_ready}, 16'h0001);
    checkOutput("async_rst_frame_done", {15'b0, frame_done}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    edges = 0;
    step();
    step();
    checkOutput("rerst_dead_an", {12'b0, an}, 16'h000F);
    step();
    checkOutput("rerst_drive_an", {12'b0, an}, 16'h000E);
    checkOutput("rerst_drive_seg", {9'b0, seg}, 16'h003F);
    runTo(32, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
